// File: rtl/fp_unpack_reader_if.sv
// fp_unpack_reader_if: valid/ready word input and decoded-field output bundle for fp_unpack_reader
interface fp_unpack_reader_if #(parameter int EXP_BITS = 8, parameter int MAN_BITS = 23);
  localparam int BITS = 1 + EXP_BITS + MAN_BITS;
  logic                in_valid;
  logic                in_ready;
  logic [BITS-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic                sign;
  logic [EXP_BITS+1:0] exponent;
  logic [MAN_BITS:0]   mantissa;
  logic [4:0]          norm_shift;
  logic                is_zero;
  logic                is_subnormal;
  logic                is_inf;
  logic                is_nan;
  logic                is_snan;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, sign, exponent, mantissa, norm_shift,
           is_zero, is_subnormal, is_inf, is_nan, is_snan
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, sign, exponent, mantissa, norm_shift,
           is_zero, is_subnormal, is_inf, is_nan, is_snan
  );
endinterface

// File: rtl/fp_unpack_reader.sv
// fp_unpack_reader: two-stage valid/ready IEEE-754 field decoder; FP_UNPACK_NORMALIZE_EN normalizes subnormals
module fp_unpack_reader #(
  parameter int EXP_BITS = 8,
  parameter int MAN_BITS = 23
) (
  input logic clk,
  input logic rst,
  fp_unpack_reader_if.slave bus
);
  localparam int BITS = 1 + EXP_BITS + MAN_BITS;
  localparam int EW = EXP_BITS + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_BITS - 1)) - 1);
  logic               r_s1_valid;
  logic [BITS-1:0]    r_s1_data;
  logic               r_s2_valid;
  logic               r_sign;
  logic [EW-1:0]      r_exp;
  logic [MAN_BITS:0]  r_man;
  logic [4:0]         r_shift;
  logic               r_zero, r_sub, r_inf, r_nan, r_snan;
  logic               w_s2_free, w_in_ready;
  logic [EXP_BITS-1:0] w_e;
  logic [MAN_BITS-1:0] w_f;
  logic               w_ez, w_em, w_fz;
  logic [4:0]         w_k;
  logic [MAN_BITS:0]  w_sub_man, w_man;
  logic [EW-1:0]      w_exp;
  assign w_s2_free  = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_free;
  assign w_e  = r_s1_data[MAN_BITS +: EXP_BITS];
  assign w_f  = r_s1_data[MAN_BITS-1:0];
  assign w_ez = w_e == '0;
  assign w_em = &w_e;
  assign w_fz = w_f == '0;
`ifdef FP_UNPACK_NORMALIZE_EN
  // highest set fraction bit wins, giving the shift that lands it on the hidden-bit position
  always_comb begin
    w_k = '0;
    for (int i = 0; i < MAN_BITS; i++) if (w_f[i]) w_k = 5'(MAN_BITS - i);
  end
  assign w_sub_man = {1'b0, w_f} << w_k;
`else
  assign w_k       = '0;
  assign w_sub_man = {1'b0, w_f};
`endif
  assign w_exp = w_ez ? (w_fz ? '0 : EW'(1) - BIAS - EW'(w_k))
               : w_em ? BIAS + EW'(1) : EW'(w_e) - BIAS;
  assign w_man = w_ez ? w_sub_man : {1'b1, w_f};
  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else if (w_in_ready) r_s1_valid <= bus.in_valid;
    if (w_in_ready && bus.in_valid) r_s1_data <= bus.in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_man      <= '0;
      r_shift    <= '0;
      r_zero     <= 1'b0;
      r_sub      <= 1'b0;
      r_inf      <= 1'b0;
      r_nan      <= 1'b0;
      r_snan     <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sign  <= r_s1_data[BITS-1];
        r_exp   <= w_exp;
        r_man   <= w_man;
        r_shift <= (w_ez && !w_fz) ? w_k : 5'd0;
        r_zero  <= w_ez && w_fz;
        r_sub   <= w_ez && !w_fz;
        r_inf   <= w_em && w_fz;
        r_nan   <= w_em && !w_fz;
        r_snan  <= w_em && !w_fz && !w_f[MAN_BITS-1];
      end
    end
  end
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_s2_valid;
  assign bus.sign         = r_sign;
  assign bus.exponent     = r_exp;
  assign bus.mantissa     = r_man;
  assign bus.norm_shift   = r_shift;
  assign bus.is_zero      = r_zero;
  assign bus.is_subnormal = r_sub;
  assign bus.is_inf       = r_inf;
  assign bus.is_nan       = r_nan;
  assign bus.is_snan      = r_snan;
endmodule
